// File: rtl/pmon_pkg.sv
// Shared constants for the power-monitor I2C target: register pointers,
// reset values and the transaction FSM state encoding.
package pmon_pkg;

  localparam logic [7:0] PTR_CONFIG    = 8'h00;
  localparam logic [7:0] PTR_SHUNT_V   = 8'h01;
  localparam logic [7:0] PTR_BUS_V     = 8'h02;
  localparam logic [7:0] PTR_POWER     = 8'h03;
  localparam logic [7:0] PTR_CURRENT   = 8'h04;
  localparam logic [7:0] PTR_CALIB     = 8'h05;
  localparam logic [7:0] PTR_MASK_EN   = 8'h06;
  localparam logic [7:0] PTR_ALERT_LIM = 8'h07;
  localparam logic [7:0] PTR_DIE_ID    = 8'hFF;

  localparam logic [15:0] CONFIG_RST = 16'h4127;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDR       = 4'd1,
    ADDR_ACK   = 4'd2,
    PTR        = 4'd3,
    PTR_ACK    = 4'd4,
    WR_MSB     = 4'd5,
    WR_MSB_ACK = 4'd6,
    WR_LSB     = 4'd7,
    WR_LSB_ACK = 4'd8,
    RD_MSB     = 4'd9,
    RD_MSB_ACK = 4'd10,
    RD_LSB     = 4'd11,
    RD_LSB_ACK = 4'd12
  } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the raw SCL/SDA pads and derives SCL edges plus START/STOP.
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // bit 0 = metastability flop, bit 1 = synchronized, bit 2 = history
  logic [2:0] r_scl_pipe;
  logic [2:0] r_sda_pipe;
  logic       w_scl_stable_hi;

  // Two-flop synchronizers plus one history flop, idle-high out of reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_pipe <= 3'b111;
      r_sda_pipe <= 3'b111;
    end else begin
      r_scl_pipe <= {r_scl_pipe[1:0], i_scl};
      r_sda_pipe <= {r_sda_pipe[1:0], i_sda};
    end
  end

  // SDA edges only count as START/STOP while SCL is high and not itself moving
  assign w_scl_stable_hi = r_scl_pipe[1] & r_scl_pipe[2];

  assign o_sda      = r_sda_pipe[1];
  assign o_scl_rise = r_scl_pipe[1] & ~r_scl_pipe[2];
  assign o_scl_fall = ~r_scl_pipe[1] & r_scl_pipe[2];
  assign o_start    = w_scl_stable_hi & r_sda_pipe[2] & ~r_sda_pipe[1];
  assign o_stop     = w_scl_stable_hi & ~r_sda_pipe[2] & r_sda_pipe[1];

endmodule

// File: rtl/pmon_i2c_target.sv
// I2C target exposing a pointer-addressed bank of 16-bit power-monitor registers.
module pmon_i2c_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h40,
  parameter logic [15:0] DIE_ID_VAL = 16'h2260
) (
  input  logic        CLK_24,
  input  logic        RESET,
  input  logic        SCL_IN,
  input  logic        SDA_IN,
  output logic        SDA_OE,
  input  logic [15:0] SHUNT_V,
  input  logic [15:0] BUS_V,
  input  logic [15:0] POWER,
  input  logic [15:0] CURRENT,
  output logic [15:0] CONFIG,
  output logic [15:0] CALIB,
  output logic [15:0] MASK_EN,
  output logic [15:0] ALERT_LIM,
  output logic        WR_STROBE,
  output logic [7:0]  WR_PTR
);
  import pmon_pkg::*;

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync u_sync (
    .i_clk      (CLK_24),
    .i_rst      (RESET),
    .i_scl      (SCL_IN),
    .i_sda      (SDA_IN),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_state_t  r_state, w_state_nxt;
  logic [3:0]  r_bit_cnt, w_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_sda_oe, w_oe_nxt;
  logic        w_snap, w_load_ptr, w_load_msb, w_commit;
  logic [7:0]  r_ptr, r_wr_msb, r_wr_ptr;
  logic [15:0] r_shadow, w_rd_val;
  logic [15:0] r_config, r_calib, r_mask_en, r_alert_lim;
  logic        r_wr_strobe;

  // Read mux feeding the shadow snapshot
  always_comb begin
    w_rd_val = 16'h0000;
    case (r_ptr)
      PTR_CONFIG:    w_rd_val = r_config;
      PTR_SHUNT_V:   w_rd_val = SHUNT_V;
      PTR_BUS_V:     w_rd_val = BUS_V;
      PTR_POWER:     w_rd_val = POWER;
      PTR_CURRENT:   w_rd_val = CURRENT;
      PTR_CALIB:     w_rd_val = r_calib;
      PTR_MASK_EN:   w_rd_val = r_mask_en;
      PTR_ALERT_LIM: w_rd_val = r_alert_lim;
      PTR_DIE_ID:    w_rd_val = DIE_ID_VAL;
      default:       w_rd_val = 16'h0000;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK_24) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath controls; bits sampled on SCL rise, SDA_OE moved on SCL fall
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_oe_nxt    = r_sda_oe;
    w_snap      = 1'b0;
    w_load_ptr  = 1'b0;
    w_load_msb  = 1'b0;
    w_commit    = 1'b0;
    if (w_stop) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else if (w_scl_rise) begin
      case (r_state)
        ADDR, PTR, WR_MSB, WR_LSB: begin
          w_shift_nxt = {r_shift[6:0], w_sda};
          w_cnt_nxt   = r_bit_cnt + 4'd1;
        end
        RD_MSB, RD_LSB:         w_cnt_nxt   = r_bit_cnt + 4'd1;
        RD_MSB_ACK, RD_LSB_ACK: w_shift_nxt = {r_shift[6:0], w_sda};
        default:                w_cnt_nxt   = r_bit_cnt;
      endcase
    end else if (w_scl_fall) begin
      case (r_state)
        ADDR: begin
          if (r_bit_cnt == 4'd8) begin
            w_cnt_nxt = 4'd0;
            if (r_shift[7:1] == SLAVE_ADDR) begin
              w_state_nxt = ADDR_ACK;
              w_oe_nxt    = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_oe_nxt    = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_bit_cnt;
          end
        end
        ADDR_ACK: begin
          w_cnt_nxt = 4'd0;
          if (r_shift[0]) begin
            w_state_nxt = RD_MSB;
            w_snap      = 1'b1;
            w_oe_nxt    = ~w_rd_val[15];
          end else begin
            w_state_nxt = PTR;
            w_oe_nxt    = 1'b0;
          end
        end
        PTR, WR_MSB, WR_LSB: begin
          if (r_bit_cnt == 4'd8) begin
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b1;
            w_load_ptr  = (r_state == PTR);
            w_load_msb  = (r_state == WR_MSB);
            w_state_nxt = (r_state == PTR) ? PTR_ACK :
                          (r_state == WR_MSB) ? WR_MSB_ACK : WR_LSB_ACK;
          end else begin
            w_cnt_nxt = r_bit_cnt;
          end
        end
        PTR_ACK: begin
          w_state_nxt = WR_MSB;
          w_oe_nxt    = 1'b0;
        end
        WR_MSB_ACK: begin
          w_state_nxt = WR_LSB;
          w_oe_nxt    = 1'b0;
        end
        WR_LSB_ACK: begin
          w_state_nxt = IDLE;
          w_oe_nxt    = 1'b0;
          w_commit    = 1'b1;
        end
        RD_MSB, RD_LSB: begin
          if (r_bit_cnt == 4'd8) begin
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
            w_state_nxt = (r_state == RD_MSB) ? RD_MSB_ACK : RD_LSB_ACK;
          end else if (r_state == RD_MSB) begin
            w_oe_nxt = ~r_shadow[4'd15 - r_bit_cnt];
          end else begin
            w_oe_nxt = ~r_shadow[4'd7 - r_bit_cnt];
          end
        end
        RD_MSB_ACK: begin
          w_cnt_nxt = 4'd0;
          if (!r_shift[0]) begin
            w_state_nxt = RD_LSB;
            w_oe_nxt    = ~r_shadow[7];
          end else begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
          end
        end
        RD_LSB_ACK: begin
          w_cnt_nxt = 4'd0;
          if (!r_shift[0]) begin
            w_state_nxt = RD_MSB;
            w_snap      = 1'b1;
            w_oe_nxt    = ~w_rd_val[15];
          end else begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Datapath: shifter, pointer, read shadow and the atomic 16-bit register commit
  always_ff @(posedge CLK_24) begin
    if (RESET) begin
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_sda_oe    <= 1'b0;
      r_ptr       <= 8'h00;
      r_wr_msb    <= 8'h00;
      r_shadow    <= 16'h0000;
      r_wr_strobe <= 1'b0;
      r_wr_ptr    <= 8'h00;
      r_config    <= CONFIG_RST;
      r_calib     <= 16'h0000;
      r_mask_en   <= 16'h0000;
      r_alert_lim <= 16'h0000;
    end else begin
      r_bit_cnt   <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_sda_oe    <= w_oe_nxt;
      r_wr_strobe <= w_commit;
      if (w_snap)     r_shadow <= w_rd_val;
      if (w_load_ptr) r_ptr    <= r_shift;
      if (w_load_msb) r_wr_msb <= r_shift;
      if (w_commit) begin
        r_wr_ptr <= r_ptr;
        case (r_ptr)
          PTR_CONFIG:    r_config    <= {r_wr_msb, r_shift};
          PTR_CALIB:     r_calib     <= {r_wr_msb, r_shift};
          PTR_MASK_EN:   r_mask_en   <= {r_wr_msb, r_shift};
          PTR_ALERT_LIM: r_alert_lim <= {r_wr_msb, r_shift};
          default:       r_wr_ptr    <= r_ptr;
        endcase
      end
    end
  end

  assign SDA_OE    = r_sda_oe;
  assign WR_STROBE = r_wr_strobe;
  assign WR_PTR    = r_wr_ptr;
  assign CONFIG    = r_config;
  assign CALIB     = r_calib;
  assign MASK_EN   = r_mask_en;
  assign ALERT_LIM = r_alert_lim;

endmodule
